// File: rtl/dpu_alu.sv
// dpu_alu: 8-bit datapath ALU with registered result and {N,Z,C,V} condition codes.
// Latency: one cycle from an accepted operation (in_valid=1 at an edge) to tr/cc/out_valid.
// Backpressure: none; an operation is accepted on every edge where in_valid=1.
module dpu_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] n,
  input  logic       in_valid,
  output logic [7:0] tr,
  output logic [3:0] cc,
  output logic       out_valid
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [7:0] tr_q, tr_d;
  logic [3:0] cc_q, cc_d;
  logic       vld_q;

  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] res;
  logic       c_flag;
  logic       v_flag;

  // Both the sum and the difference are computed one bit wider so the extra bit
  // is directly the carry (ADD) or the borrow (SUB, set iff a < b unsigned).
  assign sum9  = {1'b0, a} + {1'b0, b};
  assign diff9 = {1'b0, a} - {1'b0, b};

  // Result, carry and overflow for the selected opcode; b is unused by shifts and PASS.
  always_comb begin
    res    = 8'h00;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (n)
      OP_ADD: begin
        res    = sum9[7:0];
        c_flag = sum9[8];
        v_flag = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB: begin
        res    = diff9[7:0];
        c_flag = diff9[8];
        v_flag = (a[7] != b[7]) && (diff9[7] != a[7]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL: begin
        res    = {a[6:0], 1'b0};
        c_flag = a[7];
      end
      OP_SHR: begin
        res    = {1'b0, a[7:1]};
        c_flag = a[0];
      end
      OP_PASS: res = a;
      default: res = 8'h00;
    endcase
  end

  // Next-state: load a new result on an accepted operation, otherwise hold.
  always_comb begin
    tr_d = tr_q;
    cc_d = cc_q;
    if (in_valid) begin
      tr_d = res;
      cc_d = {res[7], (res == 8'h00), c_flag, v_flag};
    end
  end

  // Output registers; reset clears them asynchronously, discarding any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_q  <= 8'h00;
      cc_q  <= 4'b0000;
      vld_q <= 1'b0;
    end else begin
      tr_q  <= tr_d;
      cc_q  <= cc_d;
      vld_q <= in_valid;
    end
  end

  assign tr        = tr_q;
  assign cc        = cc_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_dpu_alu.sv
// Self-checking bench for dpu_alu: directed vectors, hold, async reset, random traffic.
// Expected values come from an arithmetic reference model over integers.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_dpu_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] n;
  logic       in_valid;
  logic [7:0] tr;
  logic [3:0] cc;
  logic       out_valid;

  int checks;
  int errors;

  // Reference state: what tr/cc should hold right now.
  logic [7:0] exp_tr;
  logic [3:0] exp_cc;

  dpu_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .n         (n),
    .in_valid  (in_valid),
    .tr        (tr),
    .cc        (cc),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference ALU computed with plain integer arithmetic.
  function automatic void ref_alu(input int op, input int x, input int y,
                                  output logic [7:0] r, output logic [3:0] f);
    int res;
    int s;
    bit c;
    bit v;
    res = 0; c = 0; v = 0;
    case (op)
      0: begin
        res = x + y;
        c   = (res > 255);
        s   = to_signed8(x) + to_signed8(y);
        v   = (s > 127) || (s < -128);
        res = res % 256;
      end
      1: begin
        res = (x - y + 256) % 256;
        c   = (x < y);
        s   = to_signed8(x) - to_signed8(y);
        v   = (s > 127) || (s < -128);
      end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: begin res = (x * 2) % 256; c = (x >= 128); end
      6: begin res = x / 2; c = (x % 2) == 1; end
      default: res = x;
    endcase
    r = res[7:0];
    f = {(res >= 128), (res == 0), c, v};
  endfunction

  // Drive one cycle of inputs, then wait until just after the sampling edge.
  task automatic drive_cycle(input bit v, input int op, input int x, input int y);
    @(negedge clk);
    in_valid = v;
    n        = op[2:0];
    a        = x[7:0];
    b        = y[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; n = 3'd0; a = 8'h11; b = 8'h22;
    #2;
    checks++;
    if (tr !== 8'h00 || cc !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async tr=%h cc=%b ov=%b exp 00 0000 0", tr, cc, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tr !== 8'h00 || cc !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_clocked tr=%h cc=%b ov=%b exp 00 0000 0", tr, cc, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    exp_tr = 8'h00; exp_cc = 4'b0000;
  endtask

  task automatic test_directed();
    int vec[12][6] = '{
      '{0, 8'h7F, 8'h01, 8'h80, 4'b1001, 0},
      '{0, 8'hFF, 8'h01, 8'h00, 4'b0110, 0},
      '{1, 8'h03, 8'h05, 8'hFE, 4'b1010, 0},
      '{1, 8'h05, 8'h05, 8'h00, 4'b0100, 0},
      '{5, 8'h81, 8'h5A, 8'h02, 4'b0010, 0},
      '{6, 8'h01, 8'hA5, 8'h00, 4'b0110, 0},
      '{7, 8'h0D, 8'hFF, 8'h0D, 4'b0000, 0},
      '{2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0},
      '{3, 8'hF0, 8'h3C, 8'hFC, 4'b1000, 0},
      '{4, 8'hF0, 8'h3C, 8'hCC, 4'b1000, 0},
      '{1, 8'h80, 8'h01, 8'h7F, 4'b0001, 0},
      '{0, 8'h80, 8'h80, 8'h00, 4'b0111, 0}
    };
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, vec[i][0], vec[i][1], vec[i][2]);
      checks++;
      if (tr !== vec[i][3][7:0] || cc !== vec[i][4][3:0] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d tr=%h cc=%b ov=%b exp %h %b 1",
                 i, vec[i][0], tr, cc, out_valid, vec[i][3][7:0], vec[i][4][3:0]);
      end
      exp_tr = vec[i][3][7:0];
      exp_cc = vec[i][4][3:0];
    end
  endtask

  task automatic test_hold();
    drive_cycle(1'b0, 0, 8'h55, 8'h66);
    checks++;
    if (tr !== exp_tr || cc !== exp_cc || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold tr=%h cc=%b ov=%b exp %h %b 0", tr, cc, out_valid, exp_tr, exp_cc);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 0, 8'h10, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tr !== 8'h00 || cc !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midcycle_reset tr=%h cc=%b ov=%b exp 00 0000 0", tr, cc, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 0, 2, 3);
    checks++;
    if (tr !== 8'h05 || cc !== 4'b0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_add tr=%h cc=%b ov=%b exp 05 0000 1", tr, cc, out_valid);
    end
    exp_tr = 8'h05; exp_cc = 4'b0000;
  endtask

  // Random traffic; valid_pct controls how often in_valid is high (100 = back-to-back).
  task automatic test_random(input int cycles, input int valid_pct, input string tag);
    int op, x, y;
    bit v;
    logic [7:0] r;
    logic [3:0] f;
    for (int i = 0; i < cycles; i++) begin
      v  = ($urandom_range(99) < valid_pct);
      op = $urandom_range(7);
      x  = $urandom_range(255);
      y  = $urandom_range(255);
      if (i % 16 == 0) begin x = 8'hFF * (i % 32 == 0); y = 255 - x; end
      drive_cycle(v, op, x, y);
      if (v) begin
        ref_alu(op, x, y, r, f);
        exp_tr = r;
        exp_cc = f;
      end
      checks++;
      if (tr !== exp_tr || cc !== exp_cc || out_valid !== v) begin
        errors++;
        $display("FAIL %s[%0d] op=%0d a=%h b=%h tr=%h cc=%b ov=%b exp %h %b %b",
                 tag, i, op, x[7:0], y[7:0], tr, cc, out_valid, exp_tr, exp_cc, v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_hold();
    test_random(400, 60, "random");
    test_random(200, 100, "back_to_back");
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
